// File: rtl/lr_pkg.sv
// Shared types and defaults for the linear-regression predictor.
// States, default widths and the sample-counter width.
package lr_pkg;

  localparam int LR_DATA_W    = 32;
  localparam int LR_N_SAMPLES = 20;
  localparam int LR_SSE_W     = 64;
  localparam int LR_CNT_W     = $clog2(LR_N_SAMPLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } lr_state_e;

endpackage

// File: rtl/lr_sse_acc.sv
// Sum of squared residuals with saturation at all-ones.
// err is signed; the square is formed from its magnitude.
module lr_sse_acc #(
  parameter int DATA_W = 32,
  parameter int SSE_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] err,
  output logic [SSE_W-1:0]  sse
);

  logic [DATA_W-1:0]   mag;
  logic [2*DATA_W-1:0] mag_w;
  logic [2*DATA_W-1:0] sq;
  logic [SSE_W:0]      sum;

  // -0x80..0 stays 0x80..0, which is the correct unsigned magnitude
  assign mag   = err[DATA_W-1] ? (~err + 1'b1) : err;
  assign mag_w = {{DATA_W{1'b0}}, mag};
  assign sq    = mag_w * mag_w;
  assign sum   = {1'b0, sse}
               + {{(SSE_W + 1 - 2*DATA_W){1'b0}}, sq};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sse <= '0;
    end else if (clr) begin
      sse <= '0;
    end else if (en) begin
      sse <= sum[SSE_W] ? {SSE_W{1'b1}} : sum[SSE_W-1:0];
    end
  end

endmodule

// File: rtl/lr_predictor.sv
// Streams x through y_hat = slope*x + intercept in two stages,
// reporting residuals and their running sum of squares.
module lr_predictor
  import lr_pkg::*;
#(
  parameter int DATA_W    = LR_DATA_W,
  parameter int N_SAMPLES = LR_N_SAMPLES,
  parameter int SSE_W     = LR_SSE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              coef_valid,
  output logic              coef_ready,
  input  logic [DATA_W-1:0] coef_slope,
  input  logic [DATA_W-1:0] coef_intercept,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_y_hat,
  output logic [DATA_W-1:0] out_err,
  output logic [SSE_W-1:0]  sse,
  output logic              done,
  output logic              busy
);

  localparam int CNT_W = $clog2(N_SAMPLES + 1);
  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_SAMPLES);

  lr_state_e state, state_nxt;

  logic [DATA_W-1:0] slope, intercept;
  logic [CNT_W-1:0]  cnt_in, cnt_out;
  logic              s1_valid;
  logic [DATA_W-1:0] s1_prod, s1_y;
  logic [DATA_W-1:0] y_hat_c, err_c;
  logic              stall, load, in_fire, out_fire;

  assign stall    = out_valid && !out_ready;
  assign load     = coef_valid && coef_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign in_ready = (state == RUN) && (cnt_in < N_CNT) && !stall;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (load)             state_nxt = RUN;
      RUN:   if (cnt_in == N_CNT)  state_nxt = DRAIN;
      DRAIN: if (cnt_out == N_CNT) state_nxt = DONE;
      DONE:                        state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // coef_ready stays low while reset is asserted
  always_comb begin
    coef_ready = rst_n && (state == IDLE);
    busy       = (state == RUN) || (state == DRAIN);
    done       = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slope     <= '0;
      intercept <= '0;
      cnt_in    <= '0;
      cnt_out   <= '0;
    end else if (load) begin
      slope     <= coef_slope;
      intercept <= coef_intercept;
      cnt_in    <= '0;
      cnt_out   <= '0;
    end else begin
      if (in_fire)  cnt_in  <= cnt_in + 1'b1;
      if (out_fire) cnt_out <= cnt_out + 1'b1;
    end
  end

  assign y_hat_c = s1_prod + intercept;
  assign err_c   = s1_y - y_hat_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_prod   <= '0;
      s1_y      <= '0;
      out_valid <= 1'b0;
      out_y_hat <= '0;
      out_err   <= '0;
    end else if (!stall) begin
      s1_valid  <= in_fire;
      out_valid <= s1_valid;
      if (in_fire) begin
        s1_prod <= slope * in_x;
        s1_y    <= in_y;
      end
      if (s1_valid) begin
        out_y_hat <= y_hat_c;
        out_err   <= err_c;
      end
    end
  end

  lr_sse_acc #(
    .DATA_W (DATA_W),
    .SSE_W  (SSE_W)
  ) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (load),
    .en    (out_fire),
    .err   (out_err),
    .sse   (sse)
  );

endmodule

// File: tb/tb_lr_predictor.sv
// Directed scoreboard bench for lr_predictor.
// Expected outputs are queued at input handshake, popped at output.
module tb_lr_predictor;

  localparam int N = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        coef_valid = 1'b0;
  logic        coef_ready;
  logic [31:0] coef_slope = '0;
  logic [31:0] coef_intercept = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_x = '0;
  logic [31:0] in_y = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_y_hat;
  logic [31:0] out_err;
  logic [63:0] sse;
  logic        done;
  logic        busy;

  lr_predictor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .coef_valid     (coef_valid),
    .coef_ready     (coef_ready),
    .coef_slope     (coef_slope),
    .coef_intercept (coef_intercept),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_x           (in_x),
    .in_y           (in_y),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_y_hat      (out_y_hat),
    .out_err        (out_err),
    .sse            (sse),
    .done           (done),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [31:0] xs [N];
  logic [31:0] ys [N];
  logic [63:0] q [$];
  logic [63:0] sse_m;
  int first_in, first_out;
  logic [63:0] res;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // saturating SSE reference built from a signed 64-bit square
  task automatic model_acc(input logic [31:0] e);
    longint sv;
    logic [64:0] s;
    sv = longint'($signed(e)) * longint'($signed(e));
    s = {1'b0, sse_m} + {1'b0, sv};
    sse_m = s[64] ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
  endtask

  task automatic run_pass(input logic [31:0] sl, input logic [31:0] ic,
                          input int stall_at, input int abort_at,
                          output logic [63:0] sse_end);
    int nin, nout, ndone, stall_left;
    bit stalled, aborted;
    logic [31:0] hy, he, yh;
    logic [63:0] e;
    nin = 0; nout = 0; ndone = 0; stall_left = 0;
    stalled = 0; aborted = 0; hy = '0; he = '0;
    q.delete();
    sse_m = '0;
    first_in = -1;
    first_out = -1;
    chk("coef_ready_idle", {63'd0, coef_ready}, 64'd1);
    coef_valid = 1'b1;
    coef_slope = sl;
    coef_intercept = ic;
    @(posedge clk);
    @(negedge clk);
    coef_valid = 1'b0;
    chk("busy_after_load", {63'd0, busy}, 64'd1);
    chk("sse_cleared", sse, 64'd0);
    for (int t = 0; t < 400; t++) begin
      chk("sse_running", sse, sse_m);
      if (done) begin
        ndone++;
        chk("busy_in_done", {63'd0, busy}, 64'd0);
        break;
      end
      if (out_valid && first_out < 0) first_out = cyc;
      if (abort_at >= 0 && nout == abort_at) begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_y_hat", {32'd0, out_y_hat}, 64'd0);
        chk("rst_err", {32'd0, out_err}, 64'd0);
        chk("rst_sse", sse, 64'd0);
        chk("rst_flags", {60'd0, done, busy, in_ready, coef_ready}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_coef_ready", {63'd0, coef_ready}, 64'd1);
        aborted = 1;
        break;
      end
      in_valid = (nin < N);
      in_x = (nin < N) ? xs[nin] : 32'd0;
      in_y = (nin < N) ? ys[nin] : 32'd0;
      if (stall_at >= 0 && nout == stall_at && !stalled) begin
        stalled = 1;
        stall_left = 5;
        hy = out_y_hat;
        he = out_err;
      end
      out_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        chk("stall_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_y_hat", {32'd0, out_y_hat}, {32'd0, hy});
        chk("stall_err", {32'd0, out_err}, {32'd0, he});
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        stall_left--;
      end
      if (in_valid && in_ready) begin
        yh = sl * in_x + ic;
        q.push_back({yh, in_y - yh});
        if (first_in < 0) first_in = cyc;
        nin++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("extra_output", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("y_hat", {32'd0, out_y_hat}, {32'd0, e[63:32]});
          chk("err", {32'd0, out_err}, {32'd0, e[31:0]});
          model_acc(out_err);
        end
        nout++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (!aborted) begin
      chk("done_seen", ndone, 64'd1);
      chk("out_count", nout, N);
      chk("sse_final", sse, sse_m);
      @(negedge clk);
      chk("done_one_cycle", {63'd0, done}, 64'd0);
      chk("idle_after", {62'd0, busy, coef_ready}, 64'd1);
      chk("sse_held", sse, sse_m);
    end
    sse_end = sse;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {out_valid, out_y_hat, out_err[30:0]}, 64'd0);
    chk("reset_sse", sse, 64'd0);
    chk("reset_flags", {60'd0, done, busy, in_ready, coef_ready}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < N; i++) begin
      xs[i] = i;
      ys[i] = 3 * i + 5;
    end
    run_pass(32'd3, 32'd5, -1, -1, res);
    chk("exact_sse", res, 64'd0);
    chk("latency", first_out - first_in, 64'd2);

    for (int i = 0; i < N; i++) ys[i] = 3 * i + 7;
    run_pass(32'd3, 32'd5, -1, -1, res);
    chk("const_resid_sse", res, 64'd80);

    run_pass(32'd3, 32'd5, 6, -1, res);
    chk("stall_sse", res, 64'd80);

    for (int i = 0; i < N; i++) begin
      xs[i] = 32'd1;
      ys[i] = 32'd0;
    end
    run_pass(32'hFFFF_FFFF, 32'd0, -1, -1, res);
    chk("wrap_sse", res, 64'd20);

    for (int i = 0; i < N; i++) begin
      xs[i] = i;
      ys[i] = 32'h8000_0000;
    end
    run_pass(32'd0, 32'd0, -1, -1, res);
    chk("sat_sse", res, 64'hFFFF_FFFF_FFFF_FFFF);

    for (int i = 0; i < N; i++) ys[i] = 3 * i + 7;
    run_pass(32'd3, 32'd5, -1, 7, res);
    chk("abort_no_done", {63'd0, done}, 64'd0);
    run_pass(32'd3, 32'd5, -1, -1, res);
    chk("post_abort_sse", res, 64'd80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
